// File: rtl/arm_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// arm_alu_operand_stage
//
// Operand feeder for arm_alu. Accepts one decoded ARM data-processing
// instruction together with its register values. It forms the shifter
// operand, which is a rotated immediate, an immediate-amount shift of Rm, or
// a register-amount shift of Rm. The result is registered as
// alu_op1/alu_op2/alu_op_sel together with the shifter carry-out.
//
// Immediate forms and immediate-amount shifts produce a result one cycle
// after accept. Register-amount shifts first park the instruction in the
// SHIFT state, so their result appears two cycles after accept.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready is low while in SHIFT)
//   instr           [25]=I, [24:21]=opcode, [11:0]=shifter operand field
//   rn_val          Rn value, passed through as alu_op1
//   rm_val          Rm value, source of the shifted operand
//   rs_val          Rs value, only [7:0] is used as the shift amount
//   c_flag_in       CPSR C, sampled when the instruction is accepted
//   out_valid/ready downstream handshake; outputs are held while stalled
//   alu_op1/op2     ALU operands
//   alu_op_sel      ALU opcode (instr[24:21])
//   shifter_carry   shifter carry-out for the flag logic
// ---------------------------------------------------------------------------
module arm_alu_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rn_val,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic        c_flag_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_op_sel,
    output logic        shifter_carry
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    // Rotate right by 0..31. For a non-zero amount, bit 31 of the result is
    // the last bit rotated out, so callers use it directly as the carry.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // The following three shifts take an amount of 1..32 and return
    // {carry, value}. The operand is widened by one bit so that the last bit
    // shifted out lands in that extra position.
    function automatic logic [32:0] shift_lsl(input logic [31:0] x, input logic [5:0] n);
        logic [32:0] ext;
        ext = {1'b0, x} << n;
        return {ext[32], ext[31:0]};
    endfunction

    function automatic logic [32:0] shift_lsr(input logic [31:0] x, input logic [5:0] n);
        logic [32:0] ext;
        ext = {x, 1'b0} >> n;
        return {ext[0], ext[32:1]};
    endfunction

    function automatic logic [32:0] shift_asr(input logic [31:0] x, input logic [5:0] n);
        logic signed [32:0] ext;
        ext = $signed({x, 1'b0}) >>> n;
        return {ext[0], ext[32:1]};
    endfunction

    // Full shifter operand evaluation. Returns {carry, operand2}.
    function automatic logic [32:0] shifter_operand(
        input logic        i_bit,
        input logic [11:0] op12,
        input logic [31:0] rm,
        input logic [7:0]  rs8,
        input logic        c_in
    );
        logic [4:0]  rot;
        logic [4:0]  n;
        logic [31:0] v;
        logic [32:0] res;
        res = {c_in, rm};
        if (i_bit) begin
            rot = {op12[11:8], 1'b0};
            v   = ror32({24'd0, op12[7:0]}, rot);
            res = {(rot == 5'd0) ? c_in : v[31], v};
        end else if (!op12[4]) begin
            // Immediate amount: a zero amount encodes LSR/ASR #32 and RRX.
            n = op12[11:7];
            case (op12[6:5])
                SH_LSL: res = (n == 5'd0) ? {c_in, rm} : shift_lsl(rm, {1'b0, n});
                SH_LSR: res = shift_lsr(rm, (n == 5'd0) ? 6'd32 : {1'b0, n});
                SH_ASR: res = shift_asr(rm, (n == 5'd0) ? 6'd32 : {1'b0, n});
                default: begin
                    if (n == 5'd0) begin
                        res = {rm[0], c_in, rm[31:1]};
                    end else begin
                        v   = ror32(rm, n);
                        res = {v[31], v};
                    end
                end
            endcase
        end else if (rs8 != 8'd0) begin
            // Register amount: the full 8-bit amount is significant, except
            // for ROR, which only uses the low five bits.
            case (op12[6:5])
                SH_LSL: res = (rs8 > 8'd32) ? 33'd0 : shift_lsl(rm, rs8[5:0]);
                SH_LSR: res = (rs8 > 8'd32) ? 33'd0 : shift_lsr(rm, rs8[5:0]);
                SH_ASR: res = shift_asr(rm, (rs8 >= 8'd32) ? 6'd32 : rs8[5:0]);
                default: begin
                    if (rs8[4:0] == 5'd0) begin
                        res = {rm[31], rm};
                    end else begin
                        v   = ror32(rm, rs8[4:0]);
                        res = {v[31], v};
                    end
                end
            endcase
        end
        return res;
    endfunction

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        is_reg_shift;
    logic        load_out;

    // Instruction parked for the register-shift cycle
    logic [11:0] op12_p0;
    logic [31:0] rn_p0;
    logic [31:0] rm_p0;
    logic [7:0]  rs8_p0;
    logic        c_p0;
    logic [3:0]  sel_p0;

    logic        sh_i;
    logic [11:0] sh_op12;
    logic [31:0] sh_rm;
    logic [7:0]  sh_rs8;
    logic        sh_c;
    logic [31:0] ld_op1;
    logic [3:0]  ld_sel;
    logic [32:0] sh_res;

    logic        unused_bits;
    assign unused_bits = ^{instr[31:26], instr[20:12], rs_val[31:8]};

    assign in_ready     = (state == IDLE) && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign is_reg_shift = !instr[25] && instr[4];
    assign load_out     = (state == SHIFT) || (accept && !is_reg_shift);

    // The single shifter sees live inputs in IDLE and the parked ones in SHIFT.
    always_comb begin
        sh_i    = instr[25];
        sh_op12 = instr[11:0];
        sh_rm   = rm_val;
        sh_rs8  = rs_val[7:0];
        sh_c    = c_flag_in;
        ld_op1  = rn_val;
        ld_sel  = instr[24:21];
        if (state == SHIFT) begin
            sh_i    = 1'b0;
            sh_op12 = op12_p0;
            sh_rm   = rm_p0;
            sh_rs8  = rs8_p0;
            sh_c    = c_p0;
            ld_op1  = rn_p0;
            ld_sel  = sel_p0;
        end
        sh_res = shifter_operand(sh_i, sh_op12, sh_rm, sh_rs8, sh_c);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_reg_shift) state_nxt = SHIFT;
            SHIFT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Parked register-shift operands (no reset: an abort simply leaves SHIFT)
    always_ff @(posedge clk) begin
        if (accept && is_reg_shift) begin
            op12_p0 <= instr[11:0];
            rn_p0   <= rn_val;
            rm_p0   <= rm_val;
            rs8_p0  <= rs_val[7:0];
            c_p0    <= c_flag_in;
            sel_p0  <= instr[24:21];
        end
    end

    // Output register. An accept always implies the slot is free or being
    // consumed, so a register-shift accept only needs to clear out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_op1       <= 32'd0;
            alu_op2       <= 32'd0;
            alu_op_sel    <= 4'd0;
            shifter_carry <= 1'b0;
        end else if (load_out) begin
            out_valid     <= 1'b1;
            alu_op1       <= ld_op1;
            alu_op2       <= sh_res[31:0];
            alu_op_sel    <= ld_sel;
            shifter_carry <= sh_res[32];
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arm_alu_operand_stage.sv
module tb_arm_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] rs_val;
    logic        c_flag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_op_sel;
    logic        shifter_carry;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arm_alu_operand_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rn_val        (rn_val),
        .rm_val        (rm_val),
        .rs_val        (rs_val),
        .c_flag_in     (c_flag_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_op_sel    (alu_op_sel),
        .shifter_carry (shifter_carry)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        c;
        logic [31:0] exp_op2;
        logic        exp_c;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: shifts are modelled one bit at a time, with the carry being
    // the last bit that left the word; the zero-amount encodings are special-cased.
    function automatic logic [32:0] ref_op(input logic [31:0] ins, input logic [31:0] rm,
                                           input logic [31:0] rs, input logic c);
        logic [31:0] v;
        logic        co;
        int          amt;
        int          typ;
        typ = int'(ins[6:5]);
        co  = c;
        if (ins[25]) begin
            v   = {24'd0, ins[7:0]};
            amt = 2 * int'(ins[11:8]);
            for (int i = 0; i < amt; i++) v = {v[0], v[31:1]};
            if (amt != 0) co = v[31];
            return {co, v};
        end
        if (!ins[4]) begin
            amt = int'(ins[11:7]);
            if (amt == 0) begin
                if (typ == 0) return {c, rm};
                if (typ == 3) return {rm[0], c, rm[31:1]};
                amt = 32;
            end
        end else begin
            amt = int'(rs[7:0]);
            if (amt == 0) return {c, rm};
        end
        v = rm;
        for (int i = 0; i < amt; i++) begin
            case (typ)
                0:       begin co = v[31]; v = v << 1;             end
                1:       begin co = v[0];  v = v >> 1;             end
                2:       begin co = v[0];  v = {v[31], v[31:1]};   end
                default: begin co = v[0];  v = {v[0], v[31:1]};    end
            endcase
        end
        return {co, v};
    endfunction

    // Issue one instruction with out_ready high and check the result and latency.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] rn, input logic [31:0] rm,
                          input logic [31:0] rs, input logic c, input logic [31:0] e_op2,
                          input logic e_c, input string tag);
        int lat;
        int exp_lat;
        exp_lat   = (!ins[25] && ins[4]) ? 2 : 1;
        instr     = ins;
        rn_val    = rn;
        rm_val    = rm;
        rs_val    = rs;
        c_flag_in = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        instr    = $urandom;
        rm_val   = $urandom;
        lat      = 1;
        if (exp_lat == 2) begin
            chk({tag, " in_ready_in_shift"}, {31'd0, in_ready}, 32'd0);
            chk({tag, " out_valid_in_shift"}, {31'd0, out_valid}, 32'd0);
        end
        while (!out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " op1"}, alu_op1, rn);
        chk({tag, " op_sel"}, {28'd0, alu_op_sel}, {28'd0, ins[24:21]});
        chk({tag, " op2"}, alu_op2, e_op2);
        chk({tag, " carry"}, {31'd0, shifter_carry}, {31'd0, e_c});
    endtask

    initial begin
        logic [32:0] m;
        logic [31:0] ins;
        logic [31:0] rs;

        vecs[0]  = '{32'h02A001FF, 32'h11111111, 32'h00000000, 32'h0,   1'b0, 32'hC000003F, 1'b1};
        vecs[1]  = '{32'h00400020, 32'h22222222, 32'h80000000, 32'h0,   1'b0, 32'h00000000, 1'b1};
        vecs[2]  = '{32'h00400040, 32'h33333333, 32'h80000000, 32'h0,   1'b0, 32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{32'h00800060, 32'h44444444, 32'h00000001, 32'h0,   1'b1, 32'h80000000, 1'b1};
        vecs[4]  = '{32'h00800010, 32'h55555555, 32'hFFFFFFFF, 32'd32,  1'b0, 32'h00000000, 1'b1};
        vecs[5]  = '{32'h00800010, 32'h66666666, 32'hFFFFFFFF, 32'd33,  1'b1, 32'h00000000, 1'b0};
        vecs[6]  = '{32'h00800010, 32'h77777777, 32'hFFFFFFFF, 32'd0,   1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{32'h00000200, 32'd32,       32'h12345678, 32'h0,   1'b0, 32'h23456780, 1'b1};
        vecs[8]  = '{32'h02800020, 32'd32,       32'h00000000, 32'h0,   1'b1, 32'h00000020, 1'b1};
        vecs[9]  = '{32'h01A00070, 32'h99999999, 32'h80000001, 32'd32,  1'b0, 32'h80000001, 1'b1};
        vecs[10] = '{32'h00000050, 32'hAAAAAAAA, 32'h7FFFFFFF, 32'd40,  1'b1, 32'h00000000, 1'b0};
        vecs[11] = '{32'h00800010, 32'hBBBBBBBB, 32'hFFFFFFFF, 32'h100, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{32'hFE8001FF, 32'hCCCCCCCC, 32'h00000000, 32'h0,   1'b0, 32'hC000003F, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rn_val    = 32'd0;
        rm_val    = 32'd0;
        rs_val    = 32'd0;
        c_flag_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset op1", alu_op1, 32'd0);
        chk("reset op2", alu_op2, 32'd0);
        chk("reset op_sel", {28'd0, alu_op_sel}, 32'd0);
        chk("reset carry", {31'd0, shifter_carry}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].ins, vecs[i].rn, vecs[i].rm, vecs[i].rs, vecs[i].c,
                   vecs[i].exp_op2, vecs[i].exp_c, $sformatf("vec%0d", i));

        // Backpressure: result A held for three cycles while B waits
        @(posedge clk); #1;
        instr = 32'h0280005A; rn_val = 32'h1; c_flag_in = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp first valid", {31'd0, out_valid}, 32'd1);
        instr = 32'h02400033; rn_val = 32'h2;
        for (int k = 0; k < 3; k++) begin
            chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp hold valid", {31'd0, out_valid}, 32'd1);
            chk("bp hold op2", alu_op2, 32'h0000005A);
            chk("bp hold op1", alu_op1, 32'h1);
            chk("bp hold sel", {28'd0, alu_op_sel}, 32'd4);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp second valid", {31'd0, out_valid}, 32'd1);
        chk("bp second op2", alu_op2, 32'h00000033);
        chk("bp second sel", {28'd0, alu_op_sel}, 32'd2);
        @(posedge clk); #1;
        chk("bp drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back immediates at one per cycle
        for (int k = 0; k < 4; k++) begin
            instr = 32'h02800000 | (k + 1); rn_val = k; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("stream valid", {31'd0, out_valid}, 32'd1);
            chk("stream op2", alu_op2, k + 1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while a register shift is in flight
        instr = 32'h00800010; rm_val = 32'h1; rs_val = 32'd4; rn_val = 32'h5;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort in_ready in shift", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort no emit", {31'd0, out_valid}, 32'd0);
            chk("abort op2 clear", alu_op2, 32'd0);
            @(posedge clk); #1;
        end

        // Random instructions against the reference model
        for (int k = 0; k < 150; k++) begin
            ins = $urandom;
            rs  = $urandom;
            if ($urandom_range(0, 1) == 0) rs = 32'($urandom_range(0, 40));
            c_flag_in = 1'($urandom);
            m = ref_op(ins, rm_val, rs, c_flag_in);
            run_op(ins, $urandom, rm_val, rs, c_flag_in, m[31:0], m[32], "rand");
            rm_val = $urandom;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
